adc_sar_control: RTL
====================

# adc_sar_control

Successive-approximation controller for the 12-bit SAR ADC. It runs sampling, then a binary search over the capacitor DAC, bit by bit. Its `dac_code` output is the 12-bit binary word consumed by the row/column/bincap thermometer decoder that drives the capacitor matrix. It also strobes the comparator and returns the converted result through a start/valid handshake.

## Interface
- `RESOLUTION`, 12: code width. Must equal the decoder input width (4 row + 5 col + 3 bincap bits).
- `clk`  in  1  conversion clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `sample_cycles`  in  8  sampling length N in clocks; 0 is treated as 1. Captured on accepted `start`.
- `comp_in`  in  1  comparator decision: 1 = input ≥ DAC trial level (keep bit), 0 = clear bit.
- `sample_out`  out  1  sampling switch enable.
- `comp_en`  out  1  comparator strobe; `comp_in` is valid and is sampled only in a cycle where `comp_en`=1.
- `dac_code`  out  RESOLUTION  trial code to the row/col decoder.
- `busy`  out  1  high in every state except IDLE.
- `result`  out  RESOLUTION  last completed conversion; holds until the next DONE.
- `result_valid`  out  1  one-cycle pulse when `result` is updated.

## Operation
- States: IDLE → SAMPLE → (SET → CMP) × RESOLUTION → DONE → IDLE.
- IDLE
  - All strobes are low and `dac_code`=0.
  - `start`=1 → SAMPLE. On the same edge: the sample counter loads max(`sample_cycles`,1), `bit_idx` loads RESOLUTION−1, and the code register clears.
- SAMPLE
  - `sample_out`=1 and `dac_code`=0.
  - The counter decrements each cycle. When the counter equals 1, the next state is SET.
- SET
  - `dac_code` = code | (1<<`bit_idx`).
  - `comp_en`=0 for one DAC settling cycle.
- CMP
  - `dac_code` is unchanged and `comp_en`=1.
  - On the closing edge, the code takes bit `bit_idx` = `comp_in`.
  - If `bit_idx`==0 → DONE. Otherwise `bit_idx` decrements → SET.
- DONE
  - `result` ← code is registered on entry.
  - `result_valid`=1 for exactly this cycle, then → IDLE.
- `start` is ignored whenever `busy`=1, including in DONE; no request is queued.
- Back-to-back: `start` held high gives a new SAMPLE one cycle after DONE, because the IDLE cycle is mandatory.
- `rst` during any state: next edge forces IDLE, clears code, `result`=0, and deasserts all strobes. An aborted conversion never pulses `result_valid`.

## Timing
- Reset values: `sample_out`=0, `comp_en`=0, `dac_code`=0, `busy`=0, `result`=0, `result_valid`=0.
- All outputs are driven from registers or state decode; there is no combinational path from inputs to outputs.
- Cycle numbering: `start` is accepted at edge E0. SAMPLE occupies cycles 1..N, conversion occupies cycles N+1..N+2·RESOLUTION, and DONE is cycle N+2·RESOLUTION+1.
- Start-to-`result_valid` latency is N+25 clocks at RESOLUTION=12.
- The minimum start-to-start period is N+26 clocks.
- `comp_in` is sampled only on the edge ending a CMP cycle. Its value in any other cycle is don't-care.

## Configuration
- `ADC_SAR_FAST_BIT_EN`
  - Undefined (default): two cycles per bit (SET + CMP) as described above.
  - Defined: the SET state is removed.
    - `comp_en`=1 for every conversion cycle.
    - Each cycle presents code | (1<<`bit_idx`) and captures `comp_in` on its closing edge.
    - Latency becomes N+RESOLUTION+1 (N+13).
  - The handshake, reset and `start`-ignore rules are unchanged.

## Test plan
- Comparator model `comp_in` = (VIN ≥ `dac_code`), VIN=12'hA5C, N=4, start pulse → `result`=12'hA5C, `result_valid` one cycle at E0+29. `dac_code` sequence is 800, C00 (bit 11 kept), A00, …
- Extremes: VIN=0 → `result`=000; VIN=FFF → `result`=FFF. In both cases `sample_out` is high exactly 4 cycles.
- `sample_cycles`=0 → one SAMPLE cycle and `result_valid` at E0+26. `start` pulses at cycles 5 and 26 (busy, DONE) → ignored, exactly one `result_valid`.
- `rst` asserted at cycle 15 of a conversion → next cycle all outputs are at reset values, with no `result_valid`. A fresh `start` then converts VIN=12'h123 correctly.
- `start` held high continuously, VIN alternating 12'h555/12'hAAA per conversion → results 555, AAA with valid pulses 30 clocks apart at N=4.
- With `ADC_SAR_FAST_BIT_EN`, VIN=12'hA5C, N=4 → `result`=12'hA5C at E0+17. `comp_en` is high for 12 consecutive cycles.

Source files
------------

// File: rtl/adc_sar_if.sv
// adc_sar_if: handshake, comparator and DAC signals of the SAR ADC controller
// master: the SAR controller (drives strobes, trial code and result)
// slave : the requester / analog front end (drives start, sample_cycles, comp_in)
interface adc_sar_if #(
    parameter int RESOLUTION = 12
);
    logic                  start;
    logic [7:0]            sample_cycles;
    logic                  comp_in;
    logic                  sample_out;
    logic                  comp_en;
    logic [RESOLUTION-1:0] dac_code;
    logic                  busy;
    logic [RESOLUTION-1:0] result;
    logic                  result_valid;

    modport master (
        input  start, sample_cycles, comp_in,
        output sample_out, comp_en, dac_code, busy, result, result_valid
    );

    modport slave (
        output start, sample_cycles, comp_in,
        input  sample_out, comp_en, dac_code, busy, result, result_valid
    );
endinterface

// File: rtl/adc_sar_control.sv
// adc_sar_control: successive-approximation controller for the SAR ADC
// Ports: clk, rst (sync, active high), bus (adc_sar_if.master):
//   start/sample_cycles in, comp_in in, sample_out/comp_en/dac_code out,
//   busy/result/result_valid out.
// Build option ADC_SAR_FAST_BIT_EN: drop the DAC settling cycle, one cycle per bit.
module adc_sar_control #(
    parameter int RESOLUTION = 12
) (
    input  logic        clk,
    input  logic        rst,
    adc_sar_if.master   bus
);
    localparam int IW = $clog2(RESOLUTION);

    typedef enum logic [2:0] {IDLE, SAMPLE, SET, CMP, DONE} state_t;

    state_t                state, state_n;
    logic [7:0]            cnt;
    logic [IW-1:0]         bit_idx;
    logic [RESOLUTION-1:0] code, trial, code_n;

    // The bit under test is still 0 in code, so keeping it means taking the trial word.
    assign trial  = code | (RESOLUTION'(1) << bit_idx);
    assign code_n = bus.comp_in ? trial : code;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? SAMPLE : IDLE;
`ifdef ADC_SAR_FAST_BIT_EN
            SAMPLE:  state_n = (cnt == 8'd1) ? CMP : SAMPLE;
            CMP:     state_n = (bit_idx == '0) ? DONE : CMP;
`else
            SAMPLE:  state_n = (cnt == 8'd1) ? SET : SAMPLE;
            SET:     state_n = CMP;
            CMP:     state_n = (bit_idx == '0) ? DONE : SET;
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            code    <= '0;
            bus.result <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                cnt     <= (bus.sample_cycles == 8'd0) ? 8'd1 : bus.sample_cycles;
                bit_idx <= IW'(RESOLUTION - 1);
                code    <= '0;
            end
            if (state == SAMPLE)
                cnt <= cnt - 8'd1;
            if (state == CMP) begin
                code <= code_n;
                if (bit_idx == '0)
                    bus.result <= code_n;
                else
                    bit_idx <= bit_idx - 1'b1;
            end
        end
    end

    assign bus.sample_out   = (state == SAMPLE);
    assign bus.comp_en      = (state == CMP);
    assign bus.dac_code     = (state == SET || state == CMP) ? trial : '0;
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE);
endmodule
